// File: rtl/ram_arbiter_pkg.sv
// ram_arb_pkg: shared definitions for the RAM arbiter/sequencer.
//   ADDR_W_DEFAULT : default RAM word-address width (512 words)
//   state_t        : sequencer states IDLE / RD / MRG / WR
//   PORT_I, PORT_D : port identifiers used for grant/owner tracking
//   be_merge()     : byte-enable merge of a new word into an old word
package ram_arb_pkg;

  localparam int ADDR_W_DEFAULT = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    MRG  = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Byte n of the result comes from new_word when be[n] is set, else old_word.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: core-side memory ports (instruction fetch + data).
//   i_req/i_addr        -> fetch request, byte address
//   i_ack/i_rdata       <- fetch completion pulse and data
//   d_req/d_we/d_be/d_addr/d_wdata -> data request (read, write, masked write)
//   d_ack/d_rdata       <- data completion pulse and read data
// master = the core, slave = the arbiter.
interface ram_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
    input  i_ack, i_rdata, d_ack, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
    output i_ack, i_rdata, d_ack, d_rdata
  );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, srst   : clock, synchronous active-high reset
//   req_i/req_d : requests from the fetch and data ports
//   update_en   : commit the current grant into last_grant
//   grant_valid : at least one request present
//   grant_port  : PORT_I or PORT_D (meaningful when grant_valid)
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic srst,
  input  logic req_i,
  input  logic req_d,
  input  logic update_en,
  output logic grant_valid,
  output logic grant_port
);

  logic last_grant_reg;

  always_comb begin
    grant_valid = req_i | req_d;
    if (req_i && req_d) begin
      // Tie: the port that did not win last time gets it.
      grant_port = (last_grant_reg == PORT_I) ? PORT_D : PORT_I;
    end else begin
      grant_port = req_d ? PORT_D : PORT_I;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      last_grant_reg <= PORT_I;
    end else if (update_en && grant_valid) begin
      last_grant_reg <= grant_port;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port 512x32 RAM between instruction fetch
// (read only) and the data port (read, full write, byte-masked write done
// as read-modify-write).
//   m_clock, p_reset : clock, synchronous active-high reset
//   bus              : core-side fetch/data ports (slave modport)
//   ram_addr/ram_data/ram_rden/ram_wren : RAM drive
//   ram_q            : RAM read data, valid the cycle after ram_rden
// Requests are accepted only in IDLE; the RAM command for the accepted
// request is issued combinationally in that same cycle (C0), so every
// transaction completes with its ack in C1.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
)
(
  input  logic              m_clock,
  input  logic              p_reset,
  ram_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [31:0]       ram_q
);

  state_t            state_reg;
  logic              owner_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic              grant_valid;
  logic              grant_port;
  logic              accept;
  logic [ADDR_W-1:0] win_index;
  logic              win_write;
  logic              win_full;

  // Byte offset and bits above the RAM size are ignored (2 KiB aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

  assign win_index = (grant_port == PORT_D) ? bus.d_addr[ADDR_W+1:2]
                                            : bus.i_addr[ADDR_W+1:2];
  assign win_write = (grant_port == PORT_D) && bus.d_we;
  assign win_full  = win_write && (bus.d_be == 4'hF);
  assign accept    = (state_reg == IDLE) && grant_valid && !p_reset;

  rr_arb2 u_arb (
    .clk         (m_clock),
    .srst        (p_reset),
    .req_i       (bus.i_req),
    .req_d       (bus.d_req),
    .update_en   (accept),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  // Read data is a straight pass-through; only meaningful alongside an ack.
  assign bus.i_rdata = ram_q;
  assign bus.d_rdata = ram_q;

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_reg <= IDLE;
      owner_reg <= PORT_I;
      addr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            addr_reg  <= win_index;
            owner_reg <= grant_port;
            if (!win_write)    state_reg <= RD;
            else if (win_full) state_reg <= WR;
            else               state_reg <= MRG;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // RAM drive and acks. Reset suppresses everything so an in-flight
  // transaction is dropped without an ack or a merge write.
  always_comb begin
    ram_rden  = 1'b0;
    ram_wren  = 1'b0;
    ram_addr  = addr_reg;
    ram_data  = '0;
    bus.i_ack = 1'b0;
    bus.d_ack = 1'b0;
    if (p_reset) begin
      ram_addr = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            ram_addr = win_index;
            if (win_full) begin
              ram_wren = 1'b1;
              ram_data = bus.d_wdata;
            end else begin
              // Reads and masked writes both start with a RAM read.
              ram_rden = 1'b1;
            end
          end
        end
        RD: begin
          if (owner_reg == PORT_I) bus.i_ack = 1'b1;
          else                     bus.d_ack = 1'b1;
        end
        MRG: begin
          ram_wren  = 1'b1;
          ram_data  = be_merge(ram_q, bus.d_wdata, bus.d_be);
          bus.d_ack = 1'b1;
        end
        WR: begin
          bus.d_ack = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a per-cycle vector table for the basic
// transactions, plus hand sequences for contention and reset during MRG.
module tb_ram_arbiter;

  logic        m_clock;
  logic        p_reset;
  logic [8:0]  ram_addr;
  logic [31:0] ram_data;
  logic        ram_rden;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic [31:0] mem [0:511];

  int pass_cnt  = 0;
  int total_cnt = 0;

  ram_arbiter_if bus_if();

  ram_arbiter #(.ADDR_W(9)) dut (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .bus      (bus_if),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_rden (ram_rden),
    .ram_wren (ram_wren),
    .ram_q    (ram_q)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  // RAM model: registered read, write at the clock edge.
  always @(posedge m_clock) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        e_iack;
    logic        e_dack;
    logic        e_rden;
    logic        e_wren;
    logic [8:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input string n, input logic rst,
                              input logic ireq, input logic [31:0] ia,
                              input logic dreq, input logic dwe,
                              input logic [3:0] be, input logic [31:0] da,
                              input logic [31:0] wd,
                              input logic eia, input logic eda,
                              input logic erd, input logic ewr,
                              input logic [8:0] ea, input logic [31:0] ed,
                              input logic [31:0] er);
    vec_t v;
    v.name = n; v.rst = rst; v.ireq = ireq; v.iaddr = ia; v.dreq = dreq;
    v.dwe = dwe; v.dbe = be; v.daddr = da; v.dwdata = wd;
    v.e_iack = eia; v.e_dack = eda; v.e_rden = erd; v.e_wren = ewr;
    v.e_addr = ea; v.e_data = ed; v.e_rdata = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic drive(input logic rst, input logic ireq,
                       input logic [31:0] ia, input logic dreq,
                       input logic dwe, input logic [3:0] be,
                       input logic [31:0] da, input logic [31:0] wd);
    p_reset        = rst;
    bus_if.i_req   = ireq;
    bus_if.i_addr  = ia;
    bus_if.d_req   = dreq;
    bus_if.d_we    = dwe;
    bus_if.d_be    = be;
    bus_if.d_addr  = da;
    bus_if.d_wdata = wd;
  endtask

  // Compares one cycle's outputs. Address is compared only when the RAM is
  // commanded (or in reset), write data only on writes (or in reset), read
  // data only on read acks.
  task automatic check_cycle(input string n, input logic rst, input logic dwe,
                             input logic eia, input logic eda,
                             input logic erd, input logic ewr,
                             input logic [8:0] ea, input logic [31:0] ed,
                             input logic [31:0] er);
    chk({n, ".i_ack"},    32'(bus_if.i_ack), 32'(eia));
    chk({n, ".d_ack"},    32'(bus_if.d_ack), 32'(eda));
    chk({n, ".ram_rden"}, 32'(ram_rden),     32'(erd));
    chk({n, ".ram_wren"}, 32'(ram_wren),     32'(ewr));
    chk({n, ".excl"},     32'(ram_rden & ram_wren), 32'd0);
    if (rst || erd || ewr) chk({n, ".ram_addr"}, 32'(ram_addr), 32'(ea));
    if (rst || ewr)        chk({n, ".ram_data"}, ram_data, ed);
    if (eia)               chk({n, ".i_rdata"}, bus_if.i_rdata, er);
    if (eda && !dwe)       chk({n, ".d_rdata"}, bus_if.d_rdata, er);
    $display("[%0t] %s: i_ack=%b d_ack=%b rden=%b wren=%b addr=%0d data=%h",
             $time, n, bus_if.i_ack, bus_if.d_ack, ram_rden, ram_wren,
             ram_addr, ram_data);
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    //                 name        rst ireq iaddr  dreq we be    daddr        wdata          iack dack rden wren addr  data           rdata
    vecs[0]  = mk("rst0",        1, 1, 32'h10, 1, 0, 4'hF, 32'h10,  32'h0,          0, 0, 0, 0, 9'd0, 32'h0,          32'h0);
    vecs[1]  = mk("rst1",        1, 1, 32'h10, 1, 0, 4'hF, 32'h10,  32'h0,          0, 0, 0, 0, 9'd0, 32'h0,          32'h0);
    vecs[2]  = mk("wfull_c0",    0, 1, 32'h10, 1, 1, 4'hF, 32'h10,  32'hDEADBEEF,   0, 0, 0, 1, 9'd4, 32'hDEADBEEF,   32'h0);
    vecs[3]  = mk("wfull_c1",    0, 1, 32'h10, 1, 1, 4'hF, 32'h10,  32'hDEADBEEF,   0, 1, 0, 0, 9'd0, 32'h0,          32'h0);
    vecs[4]  = mk("ifetch_c0",   0, 1, 32'h10, 1, 0, 4'hF, 32'h10,  32'h0,          0, 0, 1, 0, 9'd4, 32'h0,          32'h0);
    vecs[5]  = mk("ifetch_c1",   0, 1, 32'h10, 1, 0, 4'hF, 32'h10,  32'h0,          1, 0, 0, 0, 9'd0, 32'h0,          32'hDEADBEEF);
    vecs[6]  = mk("drd_c0",      0, 0, 32'h0,  1, 0, 4'hF, 32'h10,  32'h0,          0, 0, 1, 0, 9'd4, 32'h0,          32'h0);
    vecs[7]  = mk("drd_c1",      0, 0, 32'h0,  1, 0, 4'hF, 32'h10,  32'h0,          0, 1, 0, 0, 9'd0, 32'h0,          32'hDEADBEEF);
    vecs[8]  = mk("mrg_c0",      0, 0, 32'h0,  1, 1, 4'h5, 32'h10,  32'h11223344,   0, 0, 1, 0, 9'd4, 32'h0,          32'h0);
    vecs[9]  = mk("mrg_c1",      0, 0, 32'h0,  1, 1, 4'h5, 32'h10,  32'h11223344,   0, 1, 0, 1, 9'd4, 32'hDE22BE44,   32'h0);
    vecs[10] = mk("drd2_c0",     0, 0, 32'h0,  1, 0, 4'hF, 32'h10,  32'h0,          0, 0, 1, 0, 9'd4, 32'h0,          32'h0);
    vecs[11] = mk("drd2_c1",     0, 0, 32'h0,  1, 0, 4'hF, 32'h10,  32'h0,          0, 1, 0, 0, 9'd0, 32'h0,          32'hDE22BE44);
    vecs[12] = mk("alias_c0",    0, 0, 32'h0,  1, 1, 4'hF, 32'h800, 32'hCAFEF00D,   0, 0, 0, 1, 9'd0, 32'hCAFEF00D,   32'h0);
    vecs[13] = mk("alias_c1",    0, 0, 32'h0,  1, 1, 4'hF, 32'h800, 32'hCAFEF00D,   0, 1, 0, 0, 9'd0, 32'h0,          32'h0);
    vecs[14] = mk("be0_c0",      0, 0, 32'h0,  1, 1, 4'h0, 32'h0,   32'hFFFFFFFF,   0, 0, 1, 0, 9'd0, 32'h0,          32'h0);
    vecs[15] = mk("be0_c1",      0, 0, 32'h0,  1, 1, 4'h0, 32'h0,   32'hFFFFFFFF,   0, 1, 0, 1, 9'd0, 32'hCAFEF00D,   32'h0);
    vecs[16] = mk("drd3_c0",     0, 0, 32'h0,  1, 0, 4'hF, 32'h3,   32'h0,          0, 0, 1, 0, 9'd0, 32'h0,          32'h0);
    vecs[17] = mk("drd3_c1",     0, 0, 32'h0,  1, 0, 4'hF, 32'h3,   32'h0,          0, 1, 0, 0, 9'd0, 32'h0,          32'hCAFEF00D);
    vecs[18] = mk("idle",        0, 0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,          0, 0, 0, 0, 9'd0, 32'h0,          32'h0);

    for (int v = 0; v < 19; v++) begin
      @(negedge m_clock);
      drive(vecs[v].rst, vecs[v].ireq, vecs[v].iaddr, vecs[v].dreq,
            vecs[v].dwe, vecs[v].dbe, vecs[v].daddr, vecs[v].dwdata);
      #1;
      check_cycle(vecs[v].name, vecs[v].rst, vecs[v].dwe,
                  vecs[v].e_iack, vecs[v].e_dack, vecs[v].e_rden,
                  vecs[v].e_wren, vecs[v].e_addr, vecs[v].e_data,
                  vecs[v].e_rdata);
    end

    // Contention: reset so the first tie goes to D, then hold both requests.
    // I fetches 0x10 (word 4), D reads 0x800 (aliases word 0).
    @(negedge m_clock);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check_cycle("cont_rst", 1'b1, 1'b0, 0, 0, 0, 0, 9'd0, 32'h0, 32'h0);
    for (int k = 0; k < 16; k++) begin
      logic is_d;
      is_d = ((k / 2) % 2) == 0;
      @(negedge m_clock);
      drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0);
      #1;
      if (k % 2 == 0) begin
        check_cycle($sformatf("cont%0d_issue", k), 1'b0, 1'b0, 0, 0, 1, 0,
                    is_d ? 9'd0 : 9'd4, 32'h0, 32'h0);
      end else begin
        check_cycle($sformatf("cont%0d_ack", k), 1'b0, 1'b0, !is_d, is_d,
                    0, 0, 9'd0, 32'h0, is_d ? 32'hCAFEF00D : 32'hDE22BE44);
      end
    end
    @(negedge m_clock);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check_cycle("cont_end", 1'b0, 1'b0, 0, 0, 0, 0, 9'd0, 32'h0, 32'h0);

    // Reset in the MRG cycle: no write, no ack, word 4 stays DE22BE44.
    @(negedge m_clock);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h1, 32'h10, 32'h0);
    #1;
    check_cycle("rstmrg_c0", 1'b0, 1'b1, 0, 0, 1, 0, 9'd4, 32'h0, 32'h0);
    @(negedge m_clock);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'h1, 32'h10, 32'h0);
    #1;
    check_cycle("rstmrg_c1", 1'b1, 1'b1, 0, 0, 0, 0, 9'd0, 32'h0, 32'h0);
    @(negedge m_clock);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check_cycle("rstmrg_idle", 1'b0, 1'b0, 0, 0, 0, 0, 9'd0, 32'h0, 32'h0);
    @(negedge m_clock);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    #1;
    check_cycle("rstmrg_rd_c0", 1'b0, 1'b0, 0, 0, 1, 0, 9'd4, 32'h0, 32'h0);
    @(negedge m_clock);
    #1;
    check_cycle("rstmrg_rd_c1", 1'b0, 1'b0, 0, 1, 0, 0, 9'd0, 32'h0,
                32'hDE22BE44);
    @(negedge m_clock);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
